// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling, sticky error flags.
// Define UART_RX_PARITY_EN for 8E1 framing; default build is 8N1.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       rd,
  output logic       ready,
  output logic [7:0] data,
  output logic       overrun,
  output logic       frame_err,
  output logic       parity_err
);

  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sync_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        ready_q, ready_d;
  logic        ovr_q, ovr_d;
  logic        fe_q, fe_d;
  logic        pe_q, pe_d;
  logic        rx;
  logic        tick;

  assign rx   = sync_q[1];
  assign tick = (cnt_q == 16'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? cnt_q : cnt_q - 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = ready_q & ~rd;
    ovr_d   = ovr_q & ~rd;
    fe_d    = fe_q & ~rd;
    pe_d    = pe_q & ~rd;
    unique case (state_q)
      S_IDLE: begin
        if (!rx) begin
          state_d = S_START;
          bit_d   = 3'd0;
          cnt_d   = HALF;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = rx ? S_IDLE : S_DATA;
          cnt_d   = FULL;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {rx, shift_q[7:1]};
          cnt_d   = FULL;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          // even parity: all nine bits must xor to zero
          if (^{shift_q, rx}) pe_d = 1'b1;
          state_d = S_STOP;
          cnt_d   = FULL;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (rx) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            ovr_d   = ovr_d | (ready_q & ~rd);
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rx) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
    end
  end

  assign ready     = ready_q;
  assign data      = data_q;
  assign overrun   = ovr_q;
  assign frame_err = fe_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit.
// Randomized frames checked against a frame-level receiver model.
module tb_uart_rx;
  localparam int N = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxd = 1'b1;
  logic       rd = 1'b0;
  logic       ready;
  logic [7:0] data;
  logic       overrun;
  logic       frame_err;
  logic       parity_err;

  int n_chk = 0;
  int n_fail = 0;
  int lat = 0;

  logic       m_ready = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ovr = 1'b0;
  logic       m_fe = 1'b0;
  logic       m_pe = 1'b0;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .rd(rd),
    .ready(ready), .data(data), .overrun(overrun),
    .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] obs();
    return {ready, overrun, frame_err, parity_err, data};
  endfunction

  function automatic logic [11:0] expv();
    return {m_ready, m_ovr, m_fe, m_pe, m_data};
  endfunction

  task automatic m_good(input logic [7:0] b, input logic pok);
    if (m_ready) m_ovr = 1'b1;
    m_ready = 1'b1;
    m_data  = b;
    if (!pok) m_pe = 1'b1;
  endtask

  task automatic m_clear();
    m_ready = 1'b0;
    m_ovr   = 1'b0;
    m_fe    = 1'b0;
    m_pe    = 1'b0;
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    m_clear();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input logic pok);
    rxd = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (N) @(negedge clk);
    end
    if (PAR != 0) begin
      rxd = (^b) ^ ~pok;
      repeat (N) @(negedge clk);
    end
    rxd = stop_v;
    repeat (N) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if (obs() !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_held: got %h want %h", obs(), 12'h000);
    end
    reset = 1'b1;
    repeat (6) @(negedge clk);
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL reset_released: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1, 1'b1);
    m_good(8'hA5, 1'b1);
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL basic_a5: got %h want %h", obs(), expv());
    end
    pulse_rd();
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL basic_rd: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_glitch();
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL glitch: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_overrun();
    send_frame(8'h3C, 1'b1, 1'b1);
    m_good(8'h3C, 1'b1);
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL ovr_first: got %h want %h", obs(), expv());
    end
    send_frame(8'h81, 1'b1, 1'b1);
    m_good(8'h81, 1'b1);
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL ovr_second: got %h want %h", obs(), expv());
    end
    pulse_rd();
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL ovr_clear: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_frame_err();
    send_frame(8'h55, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    m_fe = 1'b1;
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL ferr_set: got %h want %h", obs(), expv());
    end
    pulse_rd();
    repeat (30) @(negedge clk);
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL ferr_once: got %h want %h", obs(), expv());
    end
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h12, 1'b1, 1'b1);
    m_good(8'h12, 1'b1);
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL ferr_next: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_latency();
    logic [7:0] b;
    int e;
    b = 8'($urandom);
    e = 2 + (N * 19) / 2 + N * PAR + 1;
    pulse_rd();
    lat = 0;
    fork
      send_frame(b, 1'b1, 1'b1);
      begin
        while (ready !== 1'b1 && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    n_chk++;
    if (lat < e - 1 || lat > e + 1) begin
      n_fail++;
      $display("FAIL latency: got %0d want %0d+-1", lat, e);
    end
    m_good(b, 1'b1);
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL latency_data: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_rd_same_cycle();
    fork
      send_frame(8'h7E, 1'b1, 1'b1);
      begin
        repeat (lat - 1) @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
      end
    join
    m_clear();
    m_good(8'h7E, 1'b1);
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL rd_same_cycle: got %h want %h", obs(), expv());
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    pulse_rd();
    send_frame(8'h07, 1'b1, 1'b1);
    m_good(8'h07, 1'b1);
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL parity_good: got %h want %h", obs(), expv());
    end
    pulse_rd();
    send_frame(8'h07, 1'b1, 1'b0);
    m_good(8'h07, 1'b0);
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL parity_bad: got %h want %h", obs(), expv());
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] b;
    logic       bad;
    logic       pok;
    for (int k = 0; k < 12; k++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      pok = (PAR != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if ($urandom_range(0, 1) == 1) pulse_rd();
      send_frame(b, ~bad, pok);
      if (bad) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        rxd = 1'b1;
        m_fe = 1'b1;
        if (!pok) m_pe = 1'b1;
      end else begin
        m_good(b, pok);
      end
      repeat ($urandom_range(4, 20)) @(negedge clk);
      n_chk++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL random_%0d: got %h want %h", k, obs(), expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'($urandom);
    fork
      send_frame(b, 1'b1, 1'b1);
      begin
        repeat (60) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_chk++;
        if (obs() !== 12'h000) begin
          n_fail++;
          $display("FAIL reset_async: got %h want %h", obs(), 12'h000);
        end
      end
    join
    m_clear();
    m_data = 8'h00;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'hC3, 1'b1, 1'b1);
    m_good(8'hC3, 1'b1);
    n_chk++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL reset_resume: got %h want %h", obs(), expv());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_overrun();
    test_frame_err();
    test_latency();
    test_rd_same_cycle();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: rxd  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port: rd  input  1  one-cycle consume strobe from downstream buffer.
REQ-006 SHALL have port: ready  output  1  received byte held in data.
REQ-007 SHALL have port: data  output  8  last received byte, LSB first on line.
REQ-008 SHALL have port: overrun  output  1  sticky; byte completed while ready=1 and rd=0.
REQ-009 SHALL have port: frame_err  output  1  sticky; stop bit sampled low.
REQ-010 SHALL have port: parity_err  output  1  sticky; parity mismatch (see Configuration).

Function
REQ-011 SHALL pass rxd through a 2-flop synchronizer; synchronizer flops reset to 1; all decisions use the synchronized value.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY (only with macro), STOP, WAIT_HIGH.
REQ-013 IDLE: on synchronized rxd=0 -> START, bit counter cleared, 16-bit cycle counter loaded for CLKS_PER_BIT/2 (floor).
REQ-014 START: at half-bit point, rxd=0 -> DATA with cycle counter reloaded for CLKS_PER_BIT; rxd=1 -> IDLE (glitch rejected, no flag, no output change).
REQ-015 DATA: sample every CLKS_PER_BIT cycles, shift into bit 7 of shift register (LSB first); after 8th sample -> PARITY or STOP.
REQ-016 STOP: sample at bit midpoint; rxd=1 -> byte complete, -> IDLE; rxd=0 -> frame_err set, byte discarded, -> WAIT_HIGH.
REQ-017 WAIT_HIGH: remain until synchronized rxd=1, then -> IDLE (break conditions produce exactly one frame_err event).
REQ-018 On byte complete, data SHALL update and ready SHALL be 1 in the cycle after the stop-bit sample.
REQ-019 Byte complete while ready=1 and rd=0: data overwritten with new byte, overrun set.
REQ-020 rd=1 SHALL clear ready, overrun, frame_err, parity_err in the next cycle; rd with ready=0 is harmless.
REQ-021 Simultaneous rd and completion/error event in same cycle: event wins (ready=1 with new data, or flag set); no overrun in that case.
REQ-022 data SHALL change only on byte complete; never during reception.
REQ-023 Total line-to-ready latency from start-bit falling edge: 2 sync cycles + 9.5 (10.5 with parity) bit times + 1 cycle, +-1 cycle.

Reset
REQ-024 reset=0 SHALL asynchronously force state IDLE, counters 0, shift register 0, data=8'h00, ready=0, overrun=0, frame_err=0, parity_err=0.
REQ-025 Reset deasserted mid-frame SHALL resume in IDLE; a low line at that moment is treated as a new start bit.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: frame is 8E1; PARITY state samples parity bit at midpoint; even parity over data+parity bit mismatch sets parity_err; byte still delivered (ready/data update as REQ-018).
REQ-027 Macro undefined: frame is 8N1; PARITY state absent; parity_err constant 0.

Verification (CLKS_PER_BIT=16)
REQ-028 Frame 0xA5 8N1, idle afterwards -> ready=1, data=8'hA5, all flags 0; rd pulse -> ready=0 next cycle.
REQ-029 rxd low pulse of 4 cycles then high -> returns to IDLE, ready stays 0, no flags, data unchanged.
REQ-030 Frame 0x3C then 0x81 without rd -> data=8'h81, ready=1, overrun=1; rd -> all cleared.
REQ-031 Frame 0x55 with stop bit low, line held low 40 cycles, then frame 0x12 -> frame_err=1 once, data=8'h12 after second frame.
REQ-032 rd asserted exactly in the cycle ready rises for byte 0x7E -> ready=1, data=8'h7E, overrun=0.
REQ-033 With UART_RX_PARITY_EN: 0x07 with parity 1 -> parity_err=0; with parity 0 -> parity_err=1, data=8'h07, ready=1.
